// File: rtl/hack_alu_arbiter.sv
// Two-requester round-robin front end sharing one Hack ALU, with a single
// registered result stage tagged by requester id.

module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] xz, xn, yz, yn, o;

  // zero is an AND against the inverted flag, negate is a conditional NOT
  assign xz  = x & {WIDTH{~ctrl[5]}};
  assign xn  = xz ^ {WIDTH{ctrl[4]}};
  assign yz  = y & {WIDTH{~ctrl[3]}};
  assign yn  = yz ^ {WIDTH{ctrl[2]}};
  assign o   = ctrl[1] ? (xn + yn) : (xn & yn);
  assign out = o ^ {WIDTH{ctrl[0]}};
endmodule

module hack_alu_arbiter #(
  parameter int WIDTH      = 16,
  parameter int FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [5:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [5:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic [15:0]      ops0_cnt,
  output logic [15:0]      ops1_cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             prio_q;
  logic [1:0][15:0] ops_cnt;
  logic             slot_free, grant0, grant1, accept;
  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctrl;

  assign rsp_valid = (state_q == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // grants depend only on the valids and the pointer, never on the other ready
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready = grant0 && slot_free && !rst;
  assign req1_ready = grant1 && slot_free && !rst;
  assign accept     = req0_ready || req1_ready;

  assign alu_x    = grant1 ? req1_x    : req0_x;
  assign alu_y    = grant1 ? req1_y    : req0_y;
  assign alu_ctrl = grant1 ? req1_ctrl : req0_ctrl;

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x    (alu_x),
    .y    (alu_y),
    .ctrl (alu_ctrl),
    .out  (alu_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      prio_q  <= (FIRST_PRIO != 0);
      ops_cnt <= '0;
      rsp_id  <= 1'b0;
      rsp_out <= '0;
      rsp_zr  <= 1'b0;
      rsp_ng  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_id  <= req1_ready;
        rsp_out <= alu_out;
        rsp_zr  <= (alu_out == '0);
        rsp_ng  <= alu_out[WIDTH-1];
        prio_q  <= !req1_ready;
        if (req1_ready) ops_cnt[1] <= ops_cnt[1] + 16'd1;
        else            ops_cnt[0] <= ops_cnt[0] + 16'd1;
      end
    end
  end

  assign ops0_cnt = ops_cnt[0];
  assign ops1_cnt = ops_cnt[1];
endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Randomized scoreboard bench for hack_alu_arbiter: a behavioural model predicts
// grants and results, a monitor pops expected results on each response handshake.

module tb_hack_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic [5:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zr, rsp_ng;
  logic [15:0] rsp_out, ops0_cnt, ops1_cnt;

  hack_alu_arbiter #(.WIDTH(16), .FIRST_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng),
    .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [15:0] out;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;

  // model state
  bit          m_prio;
  bit          m_valid;
  bit          m_id;
  logic [15:0] m_out;
  int          m_cnt0, m_cnt1;
  bit          acc0, acc1;

  function automatic logic [15:0] ref_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? 16'((32'(a) + 32'(b)) % 65536) : (a & b);
    if (c[0]) o = ~o;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a result is consumed on each negedge where it is offered and taken
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got result id=%0d out=%0h expected none", rsp_id, rsp_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_out", 32'(rsp_out), 32'(e.out));
        chk("sb_zr", 32'(rsp_zr), 32'(e.out == 16'h0));
        chk("sb_ng", 32'(rsp_ng), 32'(e.out[15]));
      end
    end
  end

  // One clock: drive inputs, check grants/held state at negedge, advance model at posedge.
  task automatic cycle(input bit v0, input logic [15:0] x0, input logic [15:0] y0, input logic [5:0] c0,
                       input bit v1, input logic [15:0] x1, input logic [15:0] y1, input logic [5:0] c1,
                       input bit rr);
    bit slot, g0, g1;
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_ctrl = c0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_ctrl = c1;
    rsp_ready  = rr;
    @(negedge clk);
    slot = !m_valid || rr;
    g0   = v0 && (!v1 || m_prio == 1'b0);
    g1   = v1 && (!v0 || m_prio == 1'b1);
    acc0 = g0 && slot;
    acc1 = g1 && slot;
    chk("req0_ready", 32'(req0_ready), 32'(acc0));
    chk("req1_ready", 32'(req1_ready), 32'(acc1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("held_id", 32'(rsp_id), 32'(m_id));
      chk("held_out", 32'(rsp_out), 32'(m_out));
    end
    chk("ops0_cnt", 32'(ops0_cnt), 32'(m_cnt0 % 65536));
    chk("ops1_cnt", 32'(ops1_cnt), 32'(m_cnt1 % 65536));
    @(posedge clk);
    if (acc0 || acc1) begin
      exp_t e;
      e.id  = acc1;
      e.out = acc1 ? ref_alu(x1, y1, c1) : ref_alu(x0, y0, c0);
      q.push_back(e);
      m_valid = 1'b1;
      m_id    = e.id;
      m_out   = e.out;
      m_prio  = !acc1;
      if (acc1) m_cnt1++; else m_cnt0++;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready  = 1'b0;
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_prio = 1'b0; m_valid = 1'b0; m_id = 1'b0; m_out = 16'h0;
    m_cnt0 = 0; m_cnt1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_out", 32'({rsp_id, rsp_zr, rsp_ng, rsp_out}), 32'(0));
    chk("rst_cnts", 32'({ops0_cnt, ops1_cnt}), 32'(0));
  endtask

  initial begin
    bit          p0v, p1v, rr;
    logic [15:0] p0x, p0y, p1x, p1y;
    logic [5:0]  p0c, p1c;
    bit          ids[$];

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_x = 0; req0_y = 0; req0_ctrl = 0; req1_x = 0; req1_y = 0; req1_ctrl = 0;
    #1;
    do_reset();

    // single op: 5 + 3
    cycle(1, 16'h0005, 16'h0003, 6'b000010, 0, 0, 0, 0, 1);
    chk("single_accept", 32'(acc0), 32'(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ALU coverage from requester 1
    cycle(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 6'b000000, 1);
    cycle(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 6'b101010, 1);
    cycle(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 6'b111111, 1);
    cycle(0, 0, 0, 0, 1, 16'hAAAA, 16'h5555, 6'b111010, 1);
    cycle(0, 16'hFFFF, 16'h0001, 6'b000010, 0, 0, 0, 0, 1);
    cycle(1, 16'hFFFF, 16'h0001, 6'b000010, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // contention from reset: expect 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 16'(i), 16'h0010, 6'b000010, 1, 16'(i), 16'h0100, 6'b000010, 1);
      ids.push_back(acc1);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("fair_seq", 32'({ids[0], ids[1], ids[2], ids[3]}), 32'(4'b0101));
    chk("fair_cnt0", 32'(ops0_cnt), 32'(2));
    chk("fair_cnt1", 32'(ops1_cnt), 32'(2));

    // backpressure: hold one result, both valid, 3 stall cycles, then release
    cycle(1, 16'h0101, 16'h0202, 6'b000010, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 16'h0007, 16'h0001, 6'b000010, 1, 16'h0009, 16'h0001, 6'b000010, 0);
    cycle(1, 16'h0007, 16'h0001, 6'b000010, 1, 16'h0009, 16'h0001, 6'b000010, 1);
    chk("bp_release_accept", 32'(acc1), 32'(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // mid-operation reset while holding 0x1234
    cycle(1, 16'h1234, 16'h0000, 6'b000010, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_out", 32'(rsp_out), 32'(16'h1234));
    do_reset();
    cycle(1, 16'h0001, 16'h0001, 6'b000010, 1, 16'h0002, 16'h0002, 6'b000010, 1);
    chk("post_rst_first_grant", 32'(acc0), 32'(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // randomized traffic; a pending request holds its operands until accepted
    p0v = 0; p1v = 0;
    p0x = 0; p0y = 0; p0c = 0; p1x = 0; p1y = 0; p1c = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0v && $urandom_range(0, 9) < 6) begin
        p0v = 1; p0x = 16'($urandom); p0y = 16'($urandom); p0c = 6'($urandom);
      end
      if (!p1v && $urandom_range(0, 9) < 6) begin
        p1v = 1; p1x = 16'($urandom); p1y = 16'($urandom); p1c = 6'($urandom);
      end
      rr = ($urandom_range(0, 9) < 7);
      cycle(p0v, p0x, p0y, p0c, p1v, p1x, p1y, p1c, rr);
      if (acc0) p0v = 0;
      if (acc1) p1v = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sb_drained", 32'(q.size()), 32'(0));

    // counter wrap: 65536 accepts on req0 from reset
    do_reset();
    for (int i = 0; i < 65536; i++)
      cycle(1, 16'(i), 16'h0001, 6'b000010, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("wrap_cnt0", 32'(ops0_cnt), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hack_alu_arbiter.md
Name: hack_alu_arbiter

Overview:
- Shares one Hack ALU datapath between two requesters, e.g. CPU execute stage and a debug/DMA port.
- Arbitration is round-robin. Each request and each response uses a valid/ready handshake.
- The ALU function (zx, nx, zy, ny, f, no) is implemented internally, built from the and16/not16/add16-style gates.
- Output is one registered result stage carrying a requester ID, so every result returns tagged.

Parameters:
- WIDTH, 16, datapath width of x, y and out.
- FIRST_PRIO, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_x  input  WIDTH  requester 0 operand x
- req0_y  input  WIDTH  requester 0 operand y
- req0_ctrl  input  6  requester 0 {zx,nx,zy,ny,f,no}, bit5=zx
- req1_valid  input  1  requester 1 has an operation
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_x  input  WIDTH  requester 1 operand x
- req1_y  input  WIDTH  requester 1 operand y
- req1_ctrl  input  6  requester 1 control, same encoding as req0_ctrl
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  consumer takes result this cycle
- rsp_id  output  1  requester that issued the held result
- rsp_out  output  WIDTH  ALU result
- rsp_zr  output  1  rsp_out == 0
- rsp_ng  output  1  rsp_out[WIDTH-1]
- ops0_cnt  output  16  operations accepted from requester 0
- ops1_cnt  output  16  operations accepted from requester 1

Behaviour:

Reset (rst=1 at a rising edge):
- rsp_valid=0; rsp_id, rsp_out, rsp_zr, rsp_ng = 0.
- ops0_cnt = ops1_cnt = 0.
- Priority pointer = FIRST_PRIO.
- rst overrides all other inputs that cycle. An in-flight held result is discarded.

Slot availability:
- slot_free = !rsp_valid || rsp_ready (combinational). This gives a bubble-free pipeline.

Grant (combinational):
- If only one reqN_valid is set, that requester is granted.
- If both are set, the requester named by the priority pointer is granted.
- reqN_ready = grantN && slot_free && !rst.
- At most one ready is high per cycle.
- Ready never depends on reqN_ready from the other side; there are no combinational loops through the valids.

Accept (reqN_valid && reqN_ready):
- On the next edge: rsp_valid=1, rsp_id=N, rsp_out/zr/ng = ALU(reqN_x, reqN_y, reqN_ctrl).
- opsN_cnt increments, wrapping FFFF->0000.
- Priority pointer becomes 1-N.
- Latency is exactly 1 cycle.

Drain without accept:
- rsp_valid && rsp_ready with no accept that cycle: rsp_valid=0 next edge. Data fields hold their last value.

Stall:
- rsp_valid && !rsp_ready: rsp_* are held stable, and both readies are 0.
- A requester must hold valid and operands stable until ready; the block does not check this.

Simultaneous drain and accept:
- The new result replaces the old one in the same edge, so rsp_valid stays 1.

No request, or slot not free:
- The priority pointer is unchanged.

ALU function, per Hack definition:
- x' = zx?0:x; x' = nx?~x':x'.
- Same for y with zy/ny.
- o = f ? x'+y' (mod 2^WIDTH, carry discarded) : x'&y'.
- out = no ? ~o : o.

States:
- EMPTY (rsp_valid=0) to FULL on accept.
- FULL to EMPTY on drain with no accept.
- FULL to FULL on stall or on drain+accept.

Fairness:
- With both requesters continuously valid and rsp_ready=1, grants strictly alternate 0,1,0,1… (starting at FIRST_PRIO).

Test Plan:
- Reset then single op: req0 x=0x0005, y=0x0003, ctrl=000010 (x+y) -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_out=0x0008, zr=0, ng=0; ops0_cnt=1.
- ALU coverage: req1 x=0xAAAA, y=0x5555, ctrl=000000 (x&y) -> rsp_out=0x0000, zr=1. ctrl=101010 (0) -> 0x0000. ctrl=111111 (1) -> 0x0001. ctrl=111010 (-1) -> 0xFFFF, ng=1.
- Contention, rsp_ready=1, both valid for 4 cycles, FIRST_PRIO=0 -> rsp_id sequence 0,1,0,1 on consecutive cycles; ops0_cnt=ops1_cnt=2.
- Backpressure: rsp_ready=0 with a result held and both valid -> both readies 0, rsp_* constant for 3 cycles. Raising rsp_ready -> same-cycle accept; next cycle new result with rsp_valid never dropping.
- Mid-operation reset: rsp_valid=1 holding 0x1234, assert rst one cycle -> next cycle rsp_valid=0, rsp_out=0, counters 0. First grant after reset goes to FIRST_PRIO when both valid.
- Wrap: x=0xFFFF, y=0x0001, ctrl=000010 -> rsp_out=0x0000, zr=1. Drive 65536 accepts on req0 -> ops0_cnt returns to 0x0000.
